// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and memory constants for the boot loader
package imem_loader_pkg;
   typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} state_t;
   localparam logic [31:0] NOP_INSTR  = 32'h00000013;
   localparam int          IMEM_DEPTH = 1024;
endpackage

// File: rtl/imem_loader_byte_assembler.sv
// byte_assembler: gathers four bytes into a little-endian 32-bit word
module byte_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_done
);
   logic [1:0]  r_idx;
   logic [31:0] r_shift;
   // the incoming byte lands on top so the first byte ends up in bits [7:0]
   assign word      = {byte_in, r_shift[31:8]};
   assign word_done = byte_en && (r_idx == 2'd3);
   // byte index and partial word; the index wraps 3->0 on its own
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx   <= '0;
         r_shift <= '0;
      end else if (clr) begin
         r_idx   <= '0;
         r_shift <= '0;
      end else if (byte_en) begin
         r_idx   <= r_idx + 2'd1;
         r_shift <= word;
      end
   end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed image into imem and releases the core once complete
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = IMEM_DEPTH,
   parameter int CNT_W = 11
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic             we,
   output logic [31:0]      waddr,
   output logic [31:0]      wdata,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] word_count,
   output logic             cpu_rst_n
);
   state_t           r_state;
   logic [CNT_W-1:0] r_len;
   logic             w_idle;
   logic             w_clr;
   logic             w_byte_en;
   logic [31:0]      w_word;
   logic             w_word_done;
   logic             w_bad_len;
   logic [CNT_W-1:0] w_next;

   assign w_idle    = (r_state == IDLE) || (r_state == DONE) || (r_state == ERR);
   assign w_clr     = start && w_idle;
   assign w_byte_en = rx_valid && rx_ready;
   assign w_bad_len = (w_word == 32'd0) || (w_word > 32'(DEPTH));
   assign w_next    = word_count + CNT_W'(1);

   byte_assembler u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (w_clr),
      .byte_en   (w_byte_en),
      .byte_in   (rx_data),
      .word      (w_word),
      .word_done (w_word_done)
   );

   // session FSM; every output is registered and updated alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_len      <= '0;
         rx_ready   <= 1'b0;
         we         <= 1'b0;
         waddr      <= '0;
         wdata      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
         cpu_rst_n  <= 1'b0;
      end else begin
         we <= 1'b0;
         case (r_state)
            IDLE, DONE, ERR: if (start) begin
               r_state    <= LEN;
               r_len      <= '0;
               rx_ready   <= 1'b1;
               busy       <= 1'b1;
               done       <= 1'b0;
               error      <= 1'b0;
               word_count <= '0;
               cpu_rst_n  <= 1'b0;
            end
            LEN: if (w_word_done) begin
               if (w_bad_len) begin
                  r_state  <= ERR;
                  rx_ready <= 1'b0;
                  busy     <= 1'b0;
                  error    <= 1'b1;
               end else begin
                  r_state <= DATA;
                  r_len   <= w_word[CNT_W-1:0];
               end
            end
            DATA: if (w_word_done) begin
               r_state  <= WRITE;
               rx_ready <= 1'b0;
               we       <= 1'b1;
               waddr    <= {{(30-CNT_W){1'b0}}, word_count, 2'b00};
               wdata    <= w_word;
            end
            WRITE: begin
               word_count <= w_next;
               if (w_next == r_len) begin
                  r_state   <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  cpu_rst_n <= 1'b1;
               end else begin
                  r_state  <= DATA;
                  rx_ready <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed loads with a write scoreboard checked by an independent monitor
module tb_imem_loader;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        we;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        error;
   logic [10:0] word_count;
   logic        cpu_rst_n;

   logic [63:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int n_we  = 0;

   imem_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .word_count (word_count),
      .cpu_rst_n  (cpu_rst_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: every write is matched against the next expected (addr,data)
   always @(negedge clk) begin
      if (rst_n === 1'b1 && we === 1'b1) begin
         n_we++;
         chk("rx_ready low during we", 32'(rx_ready), 32'd0);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected write: addr %h data %h, none expected", waddr, wdata);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("waddr", waddr, e[63:32]);
            chk("wdata", wdata, e[31:0]);
         end
      end
   end

   task automatic start_pulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gmax);
      int k;
      rx_valid = 1'b0;
      repeat (gmax > 0 ? $urandom_range(0, gmax) : 0) @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      k = 0;
      while (rx_ready !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (rx_ready !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rx_ready timeout: byte %h never accepted", b);
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gmax);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gmax);
   endtask

   task automatic load(input int n, input logic [31:0] seed, input int gmax);
      logic [31:0] d;
      send_word(32'(n), gmax);
      for (int i = 0; i < n; i++) begin
         d = seed ^ (32'(i) * 32'h9E3779B9);
         exp_q.push_back({32'(i * 4), d});
         send_word(d, gmax);
      end
   endtask

   task automatic wait_end(input string name);
      int k;
      k = 0;
      while (done !== 1'b1 && error !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (done !== 1'b1 && error !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s timeout: done %b error %b", name, done, error);
      end
      chk({name, " writes drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, " rx_ready"}, 32'(rx_ready), 32'd0);
      chk({name, " we"}, 32'(we), 32'd0);
      chk({name, " waddr"}, waddr, 32'd0);
      chk({name, " wdata"}, wdata, 32'd0);
      chk({name, " busy"}, 32'(busy), 32'd0);
      chk({name, " done"}, 32'(done), 32'd0);
      chk({name, " error"}, 32'(error), 32'd0);
      chk({name, " word_count"}, 32'(word_count), 32'd0);
      chk({name, " cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int we0;
      int k;
      rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // N=3 with the hand-written program
      start_pulse();
      chk("busy in LEN", 32'(busy), 32'd1);
      send_word(32'd3, 0);
      exp_q.push_back({32'h0, 32'h00000013}); send_word(32'h00000013, 0);
      exp_q.push_back({32'h4, 32'h00100093}); send_word(32'h00100093, 0);
      exp_q.push_back({32'h8, 32'h0000006F}); send_word(32'h0000006F, 0);
      wait_end("n3");
      chk("n3 done", 32'(done), 32'd1);
      chk("n3 word_count", 32'(word_count), 32'd3);
      chk("n3 cpu_rst_n", 32'(cpu_rst_n), 32'd1);
      chk("n3 busy", 32'(busy), 32'd0);

      // N=0 is rejected, then a one-word image recovers
      we0 = n_we;
      start_pulse();
      send_word(32'd0, 0);
      wait_end("n0");
      chk("n0 error", 32'(error), 32'd1);
      chk("n0 done", 32'(done), 32'd0);
      chk("n0 cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("n0 no writes", 32'(n_we - we0), 32'd0);
      start_pulse();
      chk("error cleared on start", 32'(error), 32'd0);
      exp_q.push_back({32'h0, 32'hDEADBEEF});
      send_word(32'd1, 0);
      send_word(32'hDEADBEEF, 0);
      wait_end("n1");
      chk("n1 done", 32'(done), 32'd1);
      chk("n1 error", 32'(error), 32'd0);

      // N=1025 rejected, N=1024 accepted up to the last address
      we0 = n_we;
      start_pulse();
      send_word(32'd1025, 0);
      wait_end("n1025");
      chk("n1025 error", 32'(error), 32'd1);
      chk("n1025 no writes", 32'(n_we - we0), 32'd0);
      start_pulse();
      load(1024, 32'h12345678, 0);
      wait_end("n1024");
      chk("n1024 done", 32'(done), 32'd1);
      chk("n1024 last waddr", waddr, 32'h00000FFC);
      chk("n1024 word_count", 32'(word_count), 32'd1024);

      // random gaps on rx_valid must not change the written words
      start_pulse();
      load(4, 32'hA5A50F0F, 5);
      wait_end("gaps");
      chk("gaps done", 32'(done), 32'd1);
      chk("gaps word_count", 32'(word_count), 32'd4);

      // asynchronous reset after two words of a five-word image
      start_pulse();
      send_word(32'd5, 0);
      exp_q.push_back({32'h0, 32'h11111111}); send_word(32'h11111111, 0);
      exp_q.push_back({32'h4, 32'h22222222}); send_word(32'h22222222, 0);
      k = 0;
      while (exp_q.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("pre-reset word_count", 32'(word_count), 32'd2);
      #3 rst_n = 1'b0;
      #1 chk_reset_vals("async reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_pulse();
      load(2, 32'h0BADF00D, 0);
      wait_end("after reset");
      chk("after reset done", 32'(done), 32'd2 - 32'd1);
      chk("after reset word_count", 32'(word_count), 32'd2);

      // start while busy is ignored
      start_pulse();
      send_word(32'd2, 0);
      exp_q.push_back({32'h0, 32'hCAFEF00D});
      exp_q.push_back({32'h4, 32'h76543210});
      send_byte(8'h0D, 0);
      send_byte(8'hF0, 0);
      start_pulse();
      send_byte(8'hFE, 0);
      send_byte(8'hCA, 0);
      send_word(32'h76543210, 0);
      wait_end("start in DATA");
      chk("start in DATA done", 32'(done), 32'd1);
      chk("start in DATA word_count", 32'(word_count), 32'd2);

      // start from DONE drops the core back into reset immediately
      start_pulse();
      chk("restart cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("restart word_count", 32'(word_count), 32'd0);
      chk("restart done", 32'(done), 32'd0);
      chk("restart busy", 32'(busy), 32'd1);
      send_word(32'd1, 0);
      exp_q.push_back({32'h0, 32'h00000093});
      send_word(32'h00000093, 0);
      wait_end("restart");
      chk("restart load done", 32'(done), 32'd1);
      chk("restart load cpu_rst_n", 32'(cpu_rst_n), 32'd1);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
